// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: FSM states, writeback select, alignment mask and MEM/WB record for mem_stage
package mem_stage_pkg;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RDATA, S_DONE} state_e;
    typedef enum logic [1:0] {WB_ALU, WB_LOAD, WB_PC4} wb_sel_e;
    localparam logic [1:0] ALIGN_MASK = 2'b11;
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [4:0] rd;
        logic       misalign;
        logic       bus_err;
    } mem_wb_t;
    function automatic wb_sel_e wb_select(input logic jal, input logic mem_to_reg);
        return jal ? WB_PC4 : mem_to_reg ? WB_LOAD : WB_ALU;
    endfunction
endpackage

// File: rtl/mem_stage_mem_wb.sv
// mem_wb: MEM/WB pipeline register; a bubble retires nothing but still carries error pulses
module mem_wb
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            bubble,
    input  mem_wb_t         d,
    input  logic [XLEN-1:0] d_wdata,
    output mem_wb_t         q,
    output logic [XLEN-1:0] q_wdata
);
    always_ff @(posedge clk) begin
        if (reset) begin
            q       <= '0;
            q_wdata <= '0;
        end else if (bubble) begin
            q       <= '{valid: 1'b0, reg_write: 1'b0, rd: 5'd0, misalign: d.misalign, bus_err: d.bus_err};
            q_wdata <= '0;
        end else begin
            q       <= d;
            q_wdata <= d_wdata;
        end
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage with req/gnt/rvalid bus FSM and MEM/WB register; MEM_STAGE_TIMEOUT_EN adds a bus timeout
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_rs2_val,
    input  logic [4:0]      mem_rd,
    input  logic            mem_mem_read,
    input  logic            mem_mem_write,
    input  logic            mem_reg_write,
    input  logic            mem_mem_to_reg,
    input  logic            mem_jal,
    input  logic [XLEN-1:0] mem_pc_plus4,
    output logic            dbus_req,
    output logic            dbus_we,
    output logic [XLEN-1:0] dbus_addr,
    output logic [XLEN-1:0] dbus_wdata,
    input  logic            dbus_gnt,
    input  logic            dbus_rvalid,
    input  logic [XLEN-1:0] dbus_rdata,
    output logic            mem_stall,
    output logic            wb_valid,
    output logic            wb_reg_write,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_wdata,
    output logic            misalign_err,
    output logic            bus_err
);
    state_e          state_q, state_d;
    logic            access, aligned, bubble, misalign, tmo_hit, tmo_q, bus_err_now;
    logic [XLEN-1:0] rdata_q, wdata_d;
    wb_sel_e         sel;
    mem_wb_t         wb_d, wb_q;

    assign access  = mem_mem_read || mem_mem_write;
    assign aligned = (mem_alu_result[1:0] & ALIGN_MASK) == 2'b00;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          busy, progress;
    assign busy     = state_q == S_REQ || state_q == S_RDATA;
    assign progress = (state_q == S_REQ && dbus_gnt) || (state_q == S_RDATA && dbus_rvalid);
    assign tmo_hit  = busy && !progress && cnt_q >= CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (reset || state_q == S_IDLE) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else if (busy) begin
            cnt_q <= cnt_q + 1'b1;
            tmo_q <= tmo_hit;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign tmo_q   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_RDATA && dbus_rvalid) rdata_q <= dbus_rdata;
        end
    end

    // Bus progress outranks a timeout landing in the same cycle
    always_comb begin
        state_d   = state_q;
        mem_stall = 1'b0;
        bubble    = 1'b0;
        misalign  = 1'b0;
        case (state_q)
            S_IDLE: begin
                mem_stall = access && aligned;
                bubble    = access;
                misalign  = access && !aligned;
                state_d   = (access && aligned) ? S_REQ : S_IDLE;
            end
            S_REQ: begin
                mem_stall = 1'b1;
                bubble    = 1'b1;
                state_d   = dbus_gnt ? (mem_mem_write ? S_DONE : S_RDATA) : tmo_hit ? S_DONE : S_REQ;
            end
            S_RDATA: begin
                mem_stall = 1'b1;
                bubble    = 1'b1;
                state_d   = (dbus_rvalid || tmo_hit) ? S_DONE : S_RDATA;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dbus_req    = state_q == S_REQ;
    assign dbus_we     = dbus_req && mem_mem_write;
    assign dbus_addr   = mem_alu_result;
    assign dbus_wdata  = mem_rs2_val;
    assign bus_err_now = state_q == S_DONE && tmo_q;
    assign sel         = wb_select(mem_jal, mem_mem_to_reg);
    assign wdata_d     = sel == WB_PC4 ? mem_pc_plus4 : sel == WB_LOAD ? rdata_q : mem_alu_result;
    assign wb_d        = '{valid: 1'b1, reg_write: mem_reg_write && !mem_mem_write && !bus_err_now,
                           rd: mem_rd, misalign: misalign, bus_err: bus_err_now};

    mem_wb #(.XLEN(XLEN)) u_mem_wb (
        .clk     (clk),
        .reset   (reset),
        .bubble  (bubble),
        .d       (wb_d),
        .d_wdata (wdata_d),
        .q       (wb_q),
        .q_wdata (wb_wdata)
    );

    assign wb_valid     = wb_q.valid;
    assign wb_reg_write = wb_q.reg_write;
    assign wb_rd        = wb_q.rd;
    assign misalign_err = wb_q.misalign;
    assign bus_err      = wb_q.bus_err;
endmodule
